branch_predictor: RTL
=====================

# branch_predictor

Dynamic branch predictor for the 5-stage MIPS pipeline. It is a direct-mapped branch target buffer with per-entry 2-bit saturating counters, looked up combinationally by IF with the current fetch address. It is updated by ID when a control-flow instruction resolves, and raises a same-cycle redirect when the earlier prediction was wrong. Pipelines using it have no branch delay slot: the wrong-path IF instruction is flushed on redirect.

## Interface
Parameters:
- ENTRIES, 16, BTB entry count; power of two, 2..64
- ADDR_W, 32, instruction address width
- RAS_DEPTH, 4, return-address-stack depth; power of two; used only with BP_RAS_EN
- Derived localparams: IDX_W = log2(ENTRIES); TAG_W = ADDR_W - 2 - IDX_W

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  main clock
- rst  in  1  synchronous active-high reset
- lookup_en  in  1  IF stage valid this cycle
- lookup_pc  in  ADDR_W  current fetch address
- pred_taken  out  1  predicted redirect for lookup_pc
- pred_target  out  ADDR_W  predicted next fetch address
- upd_en  in  1  ID resolves a control-flow instruction this cycle
- upd_pc  in  ADDR_W  address of the resolving instruction
- upd_kind  in  2  BR_COND / BR_JUMP / BR_CALL / BR_RET
- upd_taken  in  1  actual outcome
- upd_target  in  ADDR_W  actual taken target
- upd_pred_taken  in  1  prediction carried down the pipeline with the instruction
- upd_pred_target  in  ADDR_W  predicted target carried down the pipeline
- redirect  out  1  misprediction: flush IF and refetch
- redirect_pc  out  ADDR_W  correct next fetch address
- lookup_cnt  out  32  lookups performed
- mispred_cnt  out  32  redirects raised

## Operation
- Address fields: index = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2].
- Entry contents: valid, tag, kind, target, ctr[1:0].
- A hit requires valid and a matching tag.
- Prediction when lookup_en is high and the lookup hits:
  - JUMP or CALL: taken, target = stored target.
  - COND: taken iff ctr[1]; target = stored target if taken.
  - RET: taken, target = RAS top (see Configuration).
- Miss, or lookup_en low: pred_taken = 0, pred_target = lookup_pc + 4.
- Update on upd_en:
  - Hit on the entry: COND counter saturates up when taken, down when not taken (3 stays 3, 0 stays 0). Target is rewritten when taken.
  - Miss and taken: allocate the entry, overwriting it. ctr = 2'b10 for COND, 2'b11 otherwise.
  - Miss and not taken: no allocation.
- Redirect: redirect = upd_en & ((upd_taken != upd_pred_taken) | (upd_taken & (upd_target != upd_pred_target))).
- redirect_pc = upd_taken ? upd_target : upd_pc + 4.
- All address arithmetic is modulo 2^ADDR_W.
- Statistics: lookup_cnt increments on each lookup_en cycle; mispred_cnt increments on each redirect cycle. Both wrap at 2^32.

## Timing
- Lookup is combinational, zero latency, in the same cycle as lookup_pc.
- redirect and redirect_pc are combinational in the upd_en cycle.
- Table writes take effect at the posedge. A lookup of the same index in the update cycle sees the old contents (no bypass).
- Reset values: all valid bits 0, all counters 0, RAS empty, lookup_cnt = mispred_cnt = 0.
- While rst is high: pred_taken = 0, pred_target = lookup_pc + 4, redirect = 0, redirect_pc = 0; upd_en and lookup_en are ignored.
- rst asserted mid-stream discards any pending update in that cycle.
- At most one update per cycle. The pipeline holds upd_en low on stalled or flushed ID cycles.

## Configuration
- BP_RAS_EN defined:
  - Instantiates a RAS_DEPTH-entry return address stack.
  - Push upd_pc + 4 on an update of kind CALL. A push when full overwrites the oldest entry (circular) and occupancy stays at RAS_DEPTH.
  - Pop on an update of kind RET. A pop when empty is a no-op.
  - A RET hit predicts the RAS top, or the stored BTB target if the RAS is empty.
- BP_RAS_EN undefined: no RAS storage; RET behaves exactly as JUMP, using the stored target.

## Structure
- Shared header holds:
  - BR_COND = 2'd0, BR_JUMP = 2'd1, BR_CALL = 2'd2, BR_RET = 2'd3
  - CTR_WEAK_TAKEN = 2'b10, CTR_STRONG_TAKEN = 2'b11
  - The BP_RAS_EN default
- Sub-module bp_ras: return address stack.
  - Inputs: clk, rst, push, pop, push_addr.
  - Outputs: top, empty.
  - Only instantiated under BP_RAS_EN.

## Test plan
- Cold miss: after reset, lookup 0x0000_0040 -> pred_taken = 0, pred_target = 0x0000_0044. lookup_cnt reaches 1 the next cycle.
- COND allocation and training: taken update at 0x40 with target 0x80, upd_pred_taken = 0 -> redirect = 1, redirect_pc = 0x80, mispred_cnt = 1. The next lookup of 0x40 predicts taken to 0x80.
- Hysteresis: after two not-taken updates at 0x40 (ctr 2 -> 1 -> 0), the lookup predicts not taken with target 0x44. A third not-taken update leaves ctr at 0.
- Aliasing (ENTRIES = 16): JUMP at 0x40 then JUMP at 0x80 (same index, different tag) -> lookup of 0x40 misses; 0x80 hits.
- RAS (BP_RAS_EN, RAS_DEPTH = 4): CALLs at 0x100, 0x200, 0x300, 0x400, 0x500, then a RET hit -> predicts 0x504. After 4 further pops the RAS is empty and the RET falls back to its BTB target.
- Reset mid-stream: rst asserted together with upd_en for a taken branch -> redirect = 0, no entry allocated, both counters 0.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: control-flow kinds, counter encodings, counter update helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Build option: BP_RAS_EN is left undefined by default, so no return-address stack is built and RET
// predicts like JUMP. Define BP_RAS_EN to build the return-address stack.
package branch_predictor_pkg;

  localparam logic [1:0] BR_COND = 2'd0;
  localparam logic [1:0] BR_JUMP = 2'd1;
  localparam logic [1:0] BR_CALL = 2'd2;
  localparam logic [1:0] BR_RET  = 2'd3;

  localparam logic [1:0] CTR_WEAK_TAKEN   = 2'b10;
  localparam logic [1:0] CTR_STRONG_TAKEN = 2'b11;

  // 2-bit saturating counter step: up on taken, down on not taken, clamped at 0 and 3.
  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && ctr != 2'b11) nxt = ctr + 2'b01;
    else if (!taken && ctr != 2'b00) nxt = ctr - 2'b01;
    return nxt;
  endfunction

endpackage

// File: rtl/bp_ras.sv
// Circular return-address stack; pushing when full overwrites the oldest entry, popping when empty does nothing.
// Latency: top/empty are registered state, so a push or pop shows up on the next cycle.
// Backpressure: none; every push and pop is accepted in its cycle.
// Ports: clk, rst (sync, active-high), push/push_addr, pop; outputs top (most recent address), empty.
module bp_ras
  import branch_predictor_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_addr,
  output logic [ADDR_W-1:0] top,
  output logic              empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0] mem [2**PTR_W];
  logic [PTR_W-1:0]  ptr_q;   // slot holding the current top
  logic [PTR_W:0]    cnt_q;   // occupancy, saturates at DEPTH

  assign top   = mem[ptr_q];
  assign empty = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (push) begin
      // The pointer wraps, so a push when full lands on the oldest slot.
      ptr_q                  <= ptr_q + 1'b1;
      mem[ptr_q + 1'b1]      <= push_addr;
      if (cnt_q != (PTR_W+1)'(DEPTH)) cnt_q <= cnt_q + 1'b1;
    end else if (pop && !empty) begin
      ptr_q <= ptr_q - 1'b1;
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: combinational IF lookup, ID-stage update and misprediction redirect.
// Latency: lookup and redirect are combinational; table/counter writes land at the next posedge (no bypass).
// Backpressure: none; one lookup and one update accepted every cycle.
// Ports: clk, rst (sync, active-high); lookup_en/lookup_pc -> pred_taken/pred_target;
//        upd_* (resolved instruction + carried prediction) -> redirect/redirect_pc; lookup_cnt, mispred_cnt.
// Build option: BP_RAS_EN adds a RAS_DEPTH-entry return-address stack used for RET predictions.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES   = 16,
  parameter int ADDR_W    = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lookup_en,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_en,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic [1:0]        upd_kind,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic [ADDR_W-1:0] upd_pred_target,
  output logic              redirect,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       lookup_cnt,
  output logic [31:0]       mispred_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - 2 - IDX_W;

  if (ENTRIES < 2 || ENTRIES > 64 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_bad_entries
    $error("branch_predictor: ENTRIES must be a power of two in 2..64");
  end
  if (RAS_DEPTH < 1 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_ras_depth
    $error("branch_predictor: RAS_DEPTH must be a power of two");
  end

  // Table state: valid and ctr are reset, the payload fields are only qualified by valid.
  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q  [ENTRIES];
  logic [1:0]         kind_q [ENTRIES];
  logic [ADDR_W-1:0]  tgt_q  [ENTRIES];
  logic [1:0]         ctr_q  [ENTRIES];

  // Lookup side
  logic [IDX_W-1:0]  lk_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic              lk_hit;
  logic [ADDR_W-1:0] lk_seq;
  logic [ADDR_W-1:0] ret_target;

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[ADDR_W-1:IDX_W+2];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_seq = lookup_pc + ADDR_W'(4);

  // Update side
  logic [IDX_W-1:0]  up_idx;
  logic [TAG_W-1:0]  up_tag;
  logic              up_hit;
  logic              up_act;
  logic [ADDR_W-1:0] up_seq;

  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[ADDR_W-1:IDX_W+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign up_act = upd_en && !rst;
  assign up_seq = upd_pc + ADDR_W'(4);

`ifdef BP_RAS_EN
  logic [ADDR_W-1:0] ras_top;
  logic              ras_empty;

  bp_ras #(
    .DEPTH  (RAS_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (up_act && (upd_kind == BR_CALL)),
    .pop       (up_act && (upd_kind == BR_RET)),
    .push_addr (up_seq),
    .top       (ras_top),
    .empty     (ras_empty)
  );

  // An empty stack falls back to whatever target the BTB last recorded for this RET.
  assign ret_target = ras_empty ? tgt_q[lk_idx] : ras_top;
`else
  assign ret_target = tgt_q[lk_idx];
`endif

  always_comb begin
    pred_taken  = 1'b0;
    pred_target = lk_seq;
    if (!rst && lookup_en && lk_hit) begin
      case (kind_q[lk_idx])
        BR_COND: begin
          if (ctr_q[lk_idx][1]) begin
            pred_taken  = 1'b1;
            pred_target = tgt_q[lk_idx];
          end
        end
        BR_JUMP, BR_CALL: begin
          pred_taken  = 1'b1;
          pred_target = tgt_q[lk_idx];
        end
        default: begin // BR_RET
          pred_taken  = 1'b1;
          pred_target = ret_target;
        end
      endcase
    end
  end

  // A correct direction with a wrong target still needs a refetch.
  assign redirect    = up_act && ((upd_taken != upd_pred_taken) ||
                                  (upd_taken && (upd_target != upd_pred_target)));
  assign redirect_pc = rst ? '0 : (upd_taken ? upd_target : up_seq);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      lookup_cnt  <= '0;
      mispred_cnt <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b00;
    end else begin
      if (lookup_en) lookup_cnt <= lookup_cnt + 32'd1;
      if (redirect)  mispred_cnt <= mispred_cnt + 32'd1;
      if (upd_en) begin
        if (up_hit) begin
          if (kind_q[up_idx] == BR_COND) ctr_q[up_idx] <= ctr_step(ctr_q[up_idx], upd_taken);
          if (upd_taken) tgt_q[up_idx] <= upd_target;
        end else if (upd_taken) begin
          valid_q[up_idx] <= 1'b1;
          tag_q[up_idx]   <= up_tag;
          kind_q[up_idx]  <= upd_kind;
          tgt_q[up_idx]   <= upd_target;
          ctr_q[up_idx]   <= (upd_kind == BR_COND) ? CTR_WEAK_TAKEN : CTR_STRONG_TAKEN;
        end
      end
    end
  end

endmodule
